// File: rtl/cnt_en_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : cnt_en_gen_if
// Brief    : Button-side inputs and count-enable outputs of cnt_en_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface cnt_en_gen_if;
    logic       btn_raw;
    logic       rpt_en;
    logic       cnt_en;
    logic       pressed;
    logic [7:0] pulse_cnt;

    modport master (
        output btn_raw,
        output rpt_en,
        input  cnt_en,
        input  pressed,
        input  pulse_cnt
    );

    modport slave (
        input  btn_raw,
        input  rpt_en,
        output cnt_en,
        output pressed,
        output pulse_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cnt_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : cnt_en_gen
// Brief    : Debounces a push-button into single-cycle count-enable pulses
//            with optional auto-repeat and a saturating pulse tally.
//            Define CNT_EN_GEN_SYNC_EN to insert a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_en_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cnt_en_gen_if.slave bus
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_RPT_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_RPT_W-1:0]  c_RPT_LAST  = c_RPT_W'(REPEAT_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_DB_PRESS   = 3'd1;
    localparam logic [2:0] S_PRESSED    = 3'd2;
    localparam logic [2:0] S_REPEAT     = 3'd3;
    localparam logic [2:0] S_DB_RELEASE = 3'd4;

    logic [2:0]          r_state;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_RPT_W-1:0]  r_rpt_cnt;
    logic                r_cnt_en;
    logic                r_pressed;
    logic [7:0]          r_pulse_cnt;
    logic                w_btn_s;
    logic                w_fire;

`ifdef CNT_EN_GEN_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], bus.btn_raw};
    end

    assign w_btn_s = r_sync[1];
`else
    assign w_btn_s = bus.btn_raw;
`endif

    // Every event that issues a pulse: accepted press, first repeat, later repeats.
    assign w_fire = w_btn_s &&
                    (((r_state == S_DB_PRESS) && (r_db_cnt == c_DB_LAST)) ||
                     ((r_state == S_PRESSED)  && bus.rpt_en && (r_hold_cnt == c_HOLD_LAST)) ||
                     ((r_state == S_REPEAT)   && bus.rpt_en && (r_rpt_cnt == c_RPT_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_rpt_cnt   <= '0;
            r_cnt_en    <= 1'b0;
            r_pressed   <= 1'b0;
            r_pulse_cnt <= 8'd0;
        end else begin
            r_cnt_en <= w_fire;
            if (w_fire && (r_pulse_cnt != 8'hFF)) r_pulse_cnt <= r_pulse_cnt + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_btn_s) begin
                        r_state  <= S_DB_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                S_DB_PRESS: begin
                    if (!w_btn_s) begin
                        r_state <= S_IDLE;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state    <= S_PRESSED;
                        r_pressed  <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state  <= S_DB_RELEASE;
                        r_db_cnt <= '0;
                    end else if (bus.rpt_en && (r_hold_cnt == c_HOLD_LAST)) begin
                        r_state   <= S_REPEAT;
                        r_rpt_cnt <= '0;
                    end else if (r_hold_cnt != c_HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!w_btn_s) begin
                        r_state  <= S_DB_RELEASE;
                        r_db_cnt <= '0;
                    end else if (!bus.rpt_en) begin
                        r_state    <= S_PRESSED;
                        r_hold_cnt <= '0;
                    end else if (r_rpt_cnt == c_RPT_LAST) begin
                        r_rpt_cnt <= '0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
                S_DB_RELEASE: begin
                    // A bounce back high returns to the held state silently.
                    if (w_btn_s) begin
                        r_state    <= S_PRESSED;
                        r_hold_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_pressed <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_en    = r_cnt_en;
    assign bus.pressed   = r_pressed;
    assign bus.pulse_cnt = r_pulse_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cnt_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_en_gen
// Brief    : Self-checking bench for cnt_en_gen: run-length reference model,
//            directed scenarios with literal timing, then random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_en_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 4;
`ifdef CNT_EN_GEN_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    cnt_en_gen_if bus();

    cnt_en_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: streak = consecutive samples disagreeing with the
    // debounced level, since = edges since the hold/repeat anchor.
    bit m_down = 0, m_rep = 0, m_pulse = 0, m_s1 = 0, m_s2 = 0;
    int m_streak = 0, m_since = 0, m_total = 0;

    always @(posedge clk) begin
        bit s;
        if (rst) begin
            m_down = 0; m_rep = 0; m_pulse = 0; m_s1 = 0; m_s2 = 0;
            m_streak = 0; m_since = 0; m_total = 0;
        end else begin
`ifdef CNT_EN_GEN_SYNC_EN
            s = m_s2; m_s2 = m_s1; m_s1 = bus.btn_raw;
`else
            s = bus.btn_raw;
`endif
            m_pulse = 0;
            if (!m_down) begin
                if (s) begin
                    m_streak++;
                    if (m_streak == DEB + 1) begin
                        m_down = 1; m_streak = 0; m_since = 0; m_rep = 0; m_pulse = 1;
                    end
                end else m_streak = 0;
            end else if (!s) begin
                m_streak++;
                if (m_streak == DEB + 1) begin m_down = 0; m_streak = 0; end
            end else if (m_streak != 0) begin
                m_streak = 0; m_since = 0; m_rep = 0;
            end else if (m_rep) begin
                if (!bus.rpt_en) begin m_rep = 0; m_since = 0; end
                else begin
                    m_since++;
                    if (m_since == REP) begin m_pulse = 1; m_since = 0; end
                end
            end else begin
                if (m_since < HOLD) m_since++;
                if (bus.rpt_en && m_since >= HOLD) begin m_pulse = 1; m_rep = 1; m_since = 0; end
            end
            if (m_pulse) m_total++;
        end
    end

    always @(negedge clk) begin
        chk("model_cnt_en", int'(bus.cnt_en), int'(m_pulse));
        chk("model_pressed", int'(bus.pressed), int'(m_down));
        chk("model_pulse_cnt", int'(bus.pulse_cnt), (m_total > 255) ? 255 : m_total);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pulses;
        int run;
        bit lvl;
        bus.btn_raw = 1'b0;
        bus.rpt_en  = 1'b0;
        idle(3);
        chk("reset_cnt_en", int'(bus.cnt_en), 0);
        chk("reset_pressed", int'(bus.pressed), 0);
        chk("reset_pulse_cnt", int'(bus.pulse_cnt), 0);
        rst = 1'b0;
        idle(3);

        // Clean press, no repeat
        bus.btn_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("press_pulse", int'(bus.cnt_en), int'(i == DEB + SD));
            chk("press_level", int'(bus.pressed), int'(i >= DEB + SD));
        end
        chk("press_count", int'(bus.pulse_cnt), 1);
        bus.btn_raw = 1'b0;
        idle(12);
        chk("release_level", int'(bus.pressed), 0);

        // Bounce rejection
        for (int i = 0; i < 15; i++) begin
            bus.btn_raw = (i < 2) || (i == 3) || (i == 4);
            tick();
            chk("bounce_pulse", int'(bus.cnt_en), 0);
            chk("bounce_level", int'(bus.pressed), 0);
        end
        idle(4);
        chk("bounce_count", int'(bus.pulse_cnt), 1);

        // Auto-repeat with a release bounce
        bus.rpt_en  = 1'b1;
        bus.btn_raw = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            int e;
            tick();
            e = i - SD;
            chk("repeat_pulse", int'(bus.cnt_en),
                int'(e == 4 || (e >= 20 && e <= 40 && (e % 4) == 0)));
            bus.btn_raw = (i < 40) || (i == 41);
        end
        chk("repeat_count", int'(bus.pulse_cnt), 8);
        chk("repeat_level", int'(bus.pressed), 0);

        // Reset on the cycle a repeat pulse is high
        idle(5);
        bus.btn_raw = 1'b1;
        for (int i = 0; i <= 20 + SD; i++) tick();
        chk("rst_pre_pulse", int'(bus.cnt_en), 1);
        rst = 1'b1;
        tick();
        chk("rst_cnt_en", int'(bus.cnt_en), 0);
        chk("rst_pressed", int'(bus.pressed), 0);
        chk("rst_pulse_cnt", int'(bus.pulse_cnt), 0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rst_repress", int'(bus.cnt_en), int'(k == 5 + SD));
        end
        bus.btn_raw = 1'b0;
        bus.rpt_en  = 1'b0;
        idle(15);

        // Saturation over 300 presses
        for (int p = 0; p < 300; p++) begin
            pulses = 0;
            for (int c = 0; c < 11; c++) begin
                bus.btn_raw = (c < 5);
                tick();
                pulses += int'(bus.cnt_en);
            end
            chk("sat_press_pulse", pulses, 1);
        end
        idle(10);
        chk("sat_count", int'(bus.pulse_cnt), 255);

        // Random stimulus against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lvl = 1'b0;
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            run--;
            bus.btn_raw = lvl;
            if ($urandom_range(0, 19) == 0) bus.rpt_en = ~bus.rpt_en;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
